// File: rtl/regdst_wb_arbiter_pkg.sv
// RegDst codes, write-back FSM states and field layout shared by the write-back arbiter.
// Codes 101..111 have no destination meaning and are consumed without a write.
package regdst_pkg;

  localparam logic [2:0] RD_RT = 3'b000;
  localparam logic [2:0] RD_SP = 3'b001;
  localparam logic [2:0] RD_RA = 3'b010;
  localparam logic [2:0] RD_RD = 3'b011;
  localparam logic [2:0] RD_RS = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rd;
    logic [4:0] rt;
  } regdst_fields_t;

  function automatic logic is_legal_regdst(input logic [2:0] code);
    case (code)
      RD_RT, RD_SP, RD_RA, RD_RD, RD_RS: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regdst_wb_arbiter_if.sv
// Requester-side handshake plus register-file/mux_RegDst side of the write-back arbiter.
// master = requesters and register file environment, slave = the arbiter.
interface regdst_wb_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [3*N_REQ-1:0]      req_sel;
  logic [15*N_REQ-1:0]     req_fields;
  logic [DATA_W*N_REQ-1:0] req_data;
  logic                    wb_stall;
  logic                    reg_write;
  logic [2:0]              regdst_sel;
  logic [4:0]              regdst_rt;
  logic [4:0]              regdst_rd;
  logic [4:0]              regdst_rs;
  logic [DATA_W-1:0]       wb_data;
  logic [2:0]              wb_src;
  logic                    err_illegal;
  logic [CNT_W-1:0]        illegal_cnt;

  modport master (
    output req_valid, req_sel, req_fields, req_data, wb_stall,
    input  req_ready, reg_write, regdst_sel, regdst_rt, regdst_rd, regdst_rs,
           wb_data, wb_src, err_illegal, illegal_cnt
  );

  modport slave (
    input  req_valid, req_sel, req_fields, req_data, wb_stall,
    output req_ready, reg_write, regdst_sel, regdst_rt, regdst_rd, regdst_rs,
           wb_data, wb_src, err_illegal, illegal_cnt
  );
endinterface

// File: rtl/regdst_wb_arbiter_rr_arbiter.sv
// Round-robin pick: first set req bit at or above ptr, wrapping; one-hot gnt plus its index.
// Purely combinational; en=0 forces no grant.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    if (en) begin
      // Outer loop is the priority order starting at ptr; inner loop finds that slot.
      for (int k = 0; k < N_REQ; k++) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (!found && req[i] && (((int'(ptr) + k) % N_REQ) == i)) begin
            gnt[i]  = 1'b1;
            gnt_idx = 3'(i);
            found   = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/regdst_wb_arbiter.sv
// Round-robin owner of the register-file write port; grant registers onto outputs next cycle.
// One-deep valid/ready output stage: wb_stall freezes outputs and withholds grants, one write/cycle sustained.
module regdst_wb_arbiter
  import regdst_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input logic              clk,
  input logic              reset_n,
  regdst_wb_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  wb_state_e         state_q;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              reg_write_q;
  logic [2:0]        sel_q;
  regdst_fields_t    fields_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        src_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              load_ok;
  logic [N_REQ-1:0]  gnt;
  logic [2:0]        gnt_idx;
  logic              grant_vld;
  logic              grant_legal;
  logic [2:0]        pick_sel;
  regdst_fields_t    pick_fields;
  logic [DATA_W-1:0] pick_data;

  // reset_n gates the grant so no requester sees a handshake while in reset.
  assign load_ok = ~reg_write_q | ~bus.wb_stall;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .en      (load_ok & reset_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    pick_sel    = '0;
    pick_fields = '0;
    pick_data   = '0;
    rr_ptr_d    = rr_ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        pick_sel    = bus.req_sel[3*i +: 3];
        pick_fields = bus.req_fields[15*i +: 15];
        pick_data   = bus.req_data[DATA_W*i +: DATA_W];
        rr_ptr_d    = PTR_W'((i + 1) % N_REQ);
      end
    end
  end

  assign grant_vld   = |gnt;
  assign grant_legal = grant_vld & is_legal_regdst(pick_sel);

  always_comb begin
    cnt_d = cnt_q;
    if (grant_vld && !grant_legal && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      reg_write_q <= 1'b0;
      sel_q       <= '0;
      fields_q    <= '0;
      data_q      <= '0;
      src_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= grant_vld & ~grant_legal;
      cnt_q    <= cnt_d;

      // Illegal grants are consumed here but never reach the output register.
      if (grant_legal) begin
        sel_q    <= pick_sel;
        fields_q <= pick_fields;
        data_q   <= pick_data;
        src_q    <= gnt_idx;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (grant_legal) begin
            state_q     <= ST_WRITE;
            reg_write_q <= 1'b1;
          end
        end
        ST_WRITE, ST_HOLD: begin
          if (bus.wb_stall) begin
            state_q <= ST_HOLD;
          end else if (grant_legal) begin
            state_q     <= ST_WRITE;
            reg_write_q <= 1'b1;
          end else begin
            state_q     <= ST_IDLE;
            reg_write_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          reg_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = gnt;
  assign bus.reg_write   = reg_write_q;
  assign bus.regdst_sel  = sel_q;
  assign bus.regdst_rt   = fields_q.rt;
  assign bus.regdst_rd   = fields_q.rd;
  assign bus.regdst_rs   = fields_q.rs;
  assign bus.wb_data     = data_q;
  assign bus.wb_src      = src_q;
  assign bus.err_illegal = err_q;
  assign bus.illegal_cnt = cnt_q;

endmodule
